router_fsm: RTL and testbench

Packet-reception controller for the 1x3 router. It sits between the input port and the register/synchroniser/FIFO datapath. It decodes the header address, holds off when the target FIFO is occupied or full, and sequences the header, payload, parity and parity-check phases. It drives the Moore state-strobe outputs that the register block and the synchroniser use to steer writes.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_fsm_if.sv | 44 ++++
 rtl/router_fsm.sv | 105 ++++++++++
 tb/tb_router_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-reception controller.
package router_pkg;

  localparam int ADDR_W    = 2;
  localparam int NUM_PORTS = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

endpackage

// File: rtl/router_fsm_if.sv
// Input-port handshake, datapath status flags and state strobes of the router FSM.
interface router_fsm_if #(
  parameter int ADDR_W = router_pkg::ADDR_W
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic              fifo_empty_0;
  logic              fifo_empty_1;
  logic              fifo_empty_2;
  logic              soft_reset_0;
  logic              soft_reset_1;
  logic              soft_reset_2;
  logic              parity_done;
  logic              low_pkt_valid;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic              busy;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  write_enb_reg, rst_int_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output write_enb_reg, rst_int_reg, busy
  );

endinterface

// File: rtl/router_fsm.sv
// Packet-reception controller: header decode, full stall, parity sequencing.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header byte
// LOAD_FIRST_DATA    | header accepted, first write to the FIFO
// LOAD_DATA          | payload streaming
// FIFO_FULL_STATE    | selected FIFO full, input stalled
// LOAD_AFTER_FULL    | flush the byte held during the stall
// LOAD_PARITY        | write the parity byte
// CHECK_PARITY_ERROR | parity compare cycle
// WAIT_TILL_EMPTY    | target FIFO still occupied by a previous packet
module router_fsm #(
  parameter int ADDR_W    = router_pkg::ADDR_W,
  parameter int NUM_PORTS = router_pkg::NUM_PORTS
) (
  input  logic        clock,
  input  logic        reset,
  router_fsm_if.slave bus
);
  import router_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_mux;
  logic [2:0]        empty_vec, sr_vec;
  logic              empty_sel, sr_sel, hdr_ok;

  function automatic logic pick(input logic [2:0] flags, input logic [ADDR_W-1:0] idx);
    pick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (idx == ADDR_W'(i)) pick = flags[i];
    end
  endfunction

  assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign sr_vec    = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

  // The header byte is still on data_in during decode, so route it straight to the empty mux.
  always_comb begin
    addr_mux  = (state_q == DECODE_ADDRESS) ? bus.data_in : addr_q;
    empty_sel = pick(empty_vec, addr_mux);
    sr_sel    = pick(sr_vec, addr_q);
    hdr_ok    = bus.pkt_valid && (int'(bus.data_in) < NUM_PORTS);
  end

  always_comb begin
    addr_d = addr_q;
    if (state_q == DECODE_ADDRESS && bus.pkt_valid) addr_d = bus.data_in;
  end

  always_comb begin
    state_d = state_q;
    if (sr_sel && state_q != DECODE_ADDRESS) begin
      state_d = DECODE_ADDRESS;
    end else begin
      unique case (state_q)
        DECODE_ADDRESS: begin
          if (hdr_ok) state_d = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)        state_d = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
          else                        state_d = LOAD_DATA;
        end
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (empty_sel) state_d = LOAD_FIRST_DATA;
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    bus.detect_add    = (state_q == DECODE_ADDRESS);
    bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    bus.ld_state      = (state_q == LOAD_DATA);
    bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    bus.full_state    = (state_q == FIFO_FULL_STATE);
    bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                        || (state_q == LOAD_AFTER_FULL);
    bus.busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed phases plus randomized traffic against a packet-level model.
module tb_router_fsm;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_fsm_if #(.ADDR_W(2)) bus ();

  router_fsm dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model phases of a packet's life; named by what the controller is doing.
  localparam int PH_IDLE   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_HDR    = 2;
  localparam int PH_BODY   = 3;
  localparam int PH_STALL  = 4;
  localparam int PH_RESUME = 5;
  localparam int PH_PAR    = 6;
  localparam int PH_CHK    = 7;

  int m_ph   = PH_IDLE;
  int m_addr = 0;

  logic [7:0] obs;
  assign obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  function automatic logic [7:0] expect_outs(input int ph);
    case (ph)
      PH_IDLE:   return 8'b1000_0000;
      PH_HDR:    return 8'b0100_0001;
      PH_BODY:   return 8'b0010_0100;
      PH_STALL:  return 8'b0000_1001;
      PH_RESUME: return 8'b0001_0101;
      PH_PAR:    return 8'b0000_0101;
      PH_CHK:    return 8'b0000_0011;
      default:   return 8'b0000_0001;
    endcase
  endfunction

  task automatic model_step();
    logic [2:0] empties, srs;
    int a;
    logic emp, sr;
    if (reset) begin
      m_ph = PH_IDLE;
      m_addr = 0;
      return;
    end
    empties = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    srs     = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    a   = (m_ph == PH_IDLE) ? int'(bus.data_in) : m_addr;
    emp = (a < 3) ? empties[a] : 1'b0;
    sr  = (m_addr < 3) ? srs[m_addr] : 1'b0;
    if (m_ph == PH_IDLE && bus.pkt_valid) m_addr = int'(bus.data_in);
    if (m_ph != PH_IDLE && sr) begin
      m_ph = PH_IDLE;
    end else begin
      case (m_ph)
        PH_IDLE:   if (bus.pkt_valid && a < 3) m_ph = emp ? PH_HDR : PH_WAIT;
        PH_WAIT:   if (emp) m_ph = PH_HDR;
        PH_HDR:    m_ph = PH_BODY;
        PH_BODY:   if (bus.fifo_full) m_ph = PH_STALL; else if (!bus.pkt_valid) m_ph = PH_PAR;
        PH_STALL:  if (!bus.fifo_full) m_ph = PH_RESUME;
        PH_RESUME: m_ph = bus.parity_done ? PH_IDLE : (bus.low_pkt_valid ? PH_PAR : PH_BODY);
        PH_PAR:    m_ph = PH_CHK;
        default:   m_ph = bus.fifo_full ? PH_STALL : PH_IDLE;
      endcase
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check_eq(tag, obs, expect_outs(m_ph));
  endtask

  task automatic idle_inputs();
    bus.pkt_valid = 0; bus.data_in = 0; bus.fifo_full = 0;
    bus.fifo_empty_0 = 1; bus.fifo_empty_1 = 1; bus.fifo_empty_2 = 1;
    bus.soft_reset_0 = 0; bus.soft_reset_1 = 0; bus.soft_reset_2 = 0;
    bus.parity_done = 0; bus.low_pkt_valid = 0;
  endtask

  int ld_cnt, we_cnt, ri_cnt, cnt;

  initial begin
    idle_inputs();
    reset = 1;
    tick("reset_hold");
    tick("reset_hold");
    reset = 0;
    tick("post_reset");
    check_eq("reset_outs", obs, 8'h80);

    // Header to port 1, four payload bytes, then parity.
    bus.data_in = 2'd1; bus.pkt_valid = 1;
    tick("hdr1");
    check_eq("lfd_after_hdr", obs, 8'h41);
    ld_cnt = 0; we_cnt = 0; ri_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      bus.pkt_valid = (i < 4);
      tick("pkt1");
      ld_cnt += int'(bus.ld_state);
      we_cnt += int'(bus.write_enb_reg);
      ri_cnt += int'(bus.rst_int_reg);
    end
    check_eq("ld_cycles", ld_cnt, 4);
    check_eq("we_cycles", we_cnt, 5);
    check_eq("rst_int_cycles", ri_cnt, 1);
    check_eq("back_to_decode", obs, 8'h80);

    // Port 2 occupied for six samples, then full stall mid-payload.
    bus.data_in = 2'd2; bus.fifo_empty_2 = 0; bus.pkt_valid = 1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick("wait2");
      cnt += int'(obs == 8'h01);
    end
    check_eq("wait_cycles", cnt, 6);
    bus.fifo_empty_2 = 1;
    tick("wait_exit");
    check_eq("lfd_after_wait", obs, 8'h41);
    tick("body2");
    check_eq("ld_after_lfd", obs, 8'h24);
    bus.fifo_full = 1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick("full2");
      cnt += int'(bus.full_state);
    end
    check_eq("full_cycles", cnt, 3);
    bus.fifo_full = 0;
    tick("laf2");
    check_eq("laf_once", obs, 8'h15);
    tick("resume2");
    check_eq("ld_after_laf", obs, 8'h24);
    bus.pkt_valid = 0;
    tick("par2");
    tick("chk2");
    tick("end2");

    // Port 0 stalled; only its own soft reset aborts the packet.
    bus.data_in = 2'd0; bus.pkt_valid = 1;
    tick("hdr0");
    tick("body0");
    bus.fifo_full = 1;
    tick("full0");
    bus.soft_reset_1 = 1;
    tick("sr_other");
    check_eq("sr_other_ignored", obs, 8'h09);
    bus.soft_reset_1 = 0; bus.soft_reset_0 = 1;
    tick("sr_own");
    check_eq("sr_own_abort", obs, 8'h80);
    idle_inputs();
    tick("settle");

    // Invalid destination is dropped while the port stays free.
    bus.data_in = router_pkg::ADDR_INVALID; bus.pkt_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick("drop");
      check_eq("drop_idle", obs, 8'h80);
    end

    // Randomized traffic, including occasional resets mid-packet.
    for (int i = 0; i < 4000; i++) begin
      reset              = ($urandom_range(99, 0) < 2);
      bus.pkt_valid      = ($urandom_range(99, 0) < 85);
      bus.data_in        = 2'($urandom_range(3, 0));
      bus.fifo_full      = ($urandom_range(99, 0) < 25);
      bus.fifo_empty_0   = 1'($urandom_range(1, 0));
      bus.fifo_empty_1   = 1'($urandom_range(1, 0));
      bus.fifo_empty_2   = 1'($urandom_range(1, 0));
      bus.soft_reset_0   = ($urandom_range(99, 0) < 4);
      bus.soft_reset_1   = ($urandom_range(99, 0) < 4);
      bus.soft_reset_2   = ($urandom_range(99, 0) < 4);
      bus.parity_done    = ($urandom_range(99, 0) < 20);
      bus.low_pkt_valid  = ($urandom_range(99, 0) < 25);
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
